// File: rtl/iobus_pkg.sv
// iobus_pkg
// Shared constants and the address-decode helper for the I/O bus port hub.
//   IN_BASE_DEF / OUT_BASE_DEF : default window bases
//   OFS_*                      : register offsets past the end of each port array
//   addr_hit()                 : word-aligned exact-address match
package iobus_pkg;

    localparam logic [31:0] IN_BASE_DEF  = 32'h1100_8000;
    localparam logic [31:0] OUT_BASE_DEF = 32'h1100_C000;

    // Input window: BTN and PEND follow the N_IN data ports.
    localparam int OFS_BTN  = 0;
    localparam int OFS_PEND = 4;
    // Output window: IEN and PCLR follow the N_OUT data registers.
    localparam int OFS_IEN  = 0;
    localparam int OFS_PCLR = 4;

    function automatic logic addr_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int          byte_ofs);
        return (addr[1:0] == 2'b00) && (addr == base + 32'(byte_ofs));
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// One button bit: 2-flop synchroniser followed by a stability counter.
// The debounced output flips once the synchronised input has differed from it
// for DB_CYCLES consecutive cycles.
//   clk        : clock
//   RST        : synchronous active-high reset
//   i_btn_raw  : asynchronous raw button
//   o_btn_db   : debounced button
module btn_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic RST,
    input  logic i_btn_raw,
    output logic o_btn_db
);

    localparam logic [15:0] CNT_TC = 16'(DB_CYCLES - 1);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_db;
    logic [15:0] r_cnt;

    always_ff @(posedge clk) begin
        if (RST) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_TC) begin
                r_db  <= ~r_db;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign o_btn_db = r_db;

endmodule

// File: rtl/iobus_port_hub.sv
// iobus_port_hub
// Memory-mapped I/O hub: N_IN input ports, N_OUT output registers, BTN_W
// debounced buttons with rising-edge pending bits, enable mask and interrupt.
//   clk, RST                       : clock, synchronous active-high reset
//   iobus_addr/out/wr, iobus_in    : MCU bus (address, write data, strobe, read data)
//   in_data  [N_IN*32]             : raw input ports (port k at bits k*32 +: 32)
//   btn_raw  [BTN_W]               : asynchronous buttons
//   out_data [N_OUT*32]            : output registers (register k at bits k*32 +: 32)
//   intr                           : registered |(pending & ien)
// Build option: IOBUS_READBACK_EN adds read access to the output registers and IEN.
module iobus_port_hub
    import iobus_pkg::*;
#(
    parameter int          N_IN      = 2,
    parameter int          N_OUT     = 3,
    parameter int          BTN_W     = 5,
    parameter int          DB_CYCLES = 16,
    parameter logic [31:0] IN_BASE   = IN_BASE_DEF,
    parameter logic [31:0] OUT_BASE  = OUT_BASE_DEF
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic [31:0]           iobus_addr,
    input  logic [31:0]           iobus_out,
    input  logic                  iobus_wr,
    output logic [31:0]           iobus_in,
    input  logic [N_IN*32-1:0]    in_data,
    input  logic [BTN_W-1:0]      btn_raw,
    output logic [N_OUT*32-1:0]   out_data,
    output logic                  intr
);

    localparam int BTN_OFS  = 4 * N_IN + OFS_BTN;
    localparam int PEND_OFS = 4 * N_IN + OFS_PEND;
    localparam int IEN_OFS  = 4 * N_OUT + OFS_IEN;
    localparam int PCLR_OFS = 4 * N_OUT + OFS_PCLR;

    logic [N_OUT*32-1:0] r_out;
    logic [BTN_W-1:0]    r_ien;
    logic [BTN_W-1:0]    r_pend;
    logic [BTN_W-1:0]    r_db_d;
    logic                r_intr;

    logic [BTN_W-1:0]    w_db;
    logic [BTN_W-1:0]    w_rise;
    logic [BTN_W-1:0]    w_clr;
    logic [N_OUT-1:0]    w_out_we;
    logic                w_ien_we;
    logic                w_pclr_we;
    logic [31:0]         w_rdata;

    for (genvar g = 0; g < BTN_W; g++) begin : g_btn
        btn_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_btn_debounce (
            .clk       (clk),
            .RST       (RST),
            .i_btn_raw (btn_raw[g]),
            .o_btn_db  (w_db[g])
        );
    end

    always_comb begin
        w_out_we = '0;
        for (int k = 0; k < N_OUT; k++) begin
            w_out_we[k] = iobus_wr && addr_hit(iobus_addr, OUT_BASE, 4 * k);
        end
        w_ien_we  = iobus_wr && addr_hit(iobus_addr, OUT_BASE, IEN_OFS);
        w_pclr_we = iobus_wr && addr_hit(iobus_addr, OUT_BASE, PCLR_OFS);
    end

    assign w_rise = w_db & ~r_db_d;
    assign w_clr  = w_pclr_we ? iobus_out[BTN_W-1:0] : '0;

    always_ff @(posedge clk) begin
        if (RST) begin
            r_out  <= '0;
            r_ien  <= '0;
            r_pend <= '0;
            r_db_d <= '0;
            r_intr <= 1'b0;
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                if (w_out_we[k]) begin
                    r_out[k*32 +: 32] <= iobus_out;
                end
            end
            if (w_ien_we) begin
                r_ien <= iobus_out[BTN_W-1:0];
            end
            r_db_d <= w_db;
            // Clear applied first so a same-cycle rising edge wins.
            r_pend <= (r_pend & ~w_clr) | w_rise;
            r_intr <= |(r_pend & r_ien);
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (addr_hit(iobus_addr, IN_BASE, 4 * k)) begin
                w_rdata = in_data[k*32 +: 32];
            end
        end
        if (addr_hit(iobus_addr, IN_BASE, BTN_OFS)) begin
            w_rdata = 32'(w_db);
        end
        if (addr_hit(iobus_addr, IN_BASE, PEND_OFS)) begin
            w_rdata = 32'(r_pend);
        end
`ifdef IOBUS_READBACK_EN
        for (int k = 0; k < N_OUT; k++) begin
            if (addr_hit(iobus_addr, OUT_BASE, 4 * k)) begin
                w_rdata = r_out[k*32 +: 32];
            end
        end
        if (addr_hit(iobus_addr, OUT_BASE, IEN_OFS)) begin
            w_rdata = 32'(r_ien);
        end
`endif
    end

    assign iobus_in = w_rdata;
    assign out_data = r_out;
    assign intr     = r_intr;

endmodule

// File: tb/tb_iobus_port_hub.sv
module tb_iobus_port_hub;

    localparam int N_IN      = 2;
    localparam int N_OUT     = 3;
    localparam int BTN_W     = 5;
    localparam int DB_CYCLES = 16;
    localparam int DB_LAT    = DB_CYCLES + 2;

    localparam logic [31:0] A_IN0  = 32'h1100_8000;
    localparam logic [31:0] A_IN1  = 32'h1100_8004;
    localparam logic [31:0] A_BTN  = 32'h1100_8008;
    localparam logic [31:0] A_PEND = 32'h1100_800C;
    localparam logic [31:0] A_OUT0 = 32'h1100_C000;
    localparam logic [31:0] A_OUT1 = 32'h1100_C004;
    localparam logic [31:0] A_OUT2 = 32'h1100_C008;
    localparam logic [31:0] A_IEN  = 32'h1100_C00C;
    localparam logic [31:0] A_PCLR = 32'h1100_C010;

    logic                 clk;
    logic                 RST;
    logic [31:0]          iobus_addr;
    logic [31:0]          iobus_out;
    logic                 iobus_wr;
    logic [31:0]          iobus_in;
    logic [N_IN*32-1:0]   in_data;
    logic [BTN_W-1:0]     btn_raw;
    logic [N_OUT*32-1:0]  out_data;
    logic                 intr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    iobus_port_hub #(
        .N_IN      (N_IN),
        .N_OUT     (N_OUT),
        .BTN_W     (BTN_W),
        .DB_CYCLES (DB_CYCLES),
        .IN_BASE   (32'h1100_8000),
        .OUT_BASE  (32'h1100_C000)
    ) dut (
        .clk        (clk),
        .RST        (RST),
        .iobus_addr (iobus_addr),
        .iobus_out  (iobus_out),
        .iobus_wr   (iobus_wr),
        .iobus_in   (iobus_in),
        .in_data    (in_data),
        .btn_raw    (btn_raw),
        .out_data   (out_data),
        .intr       (intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_exp(input string tag, input logic [31:0] val);
        tag_q.push_back(tag);
        exp_q.push_back(val);
    endtask

    task automatic sb_cmp(input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            chk(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
        iobus_addr = addr;
        iobus_out  = data;
        iobus_wr   = 1'b1;
        tick();
        iobus_wr   = 1'b0;
        iobus_out  = '0;
    endtask

    task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data);
        iobus_addr = addr;
        iobus_wr   = 1'b0;
        #1;
        data = iobus_in;
    endtask

    // Ticks until BTN bit b reads lvl; returns the edge count or -1 on timeout.
    task automatic wait_btn(input int b, input logic lvl, output int n);
        n = -1;
        iobus_addr = A_BTN;
        iobus_wr   = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (iobus_in[b] === lvl) begin
                n = i;
                break;
            end
        end
    endtask

    logic [31:0] rd;
    int          n;
    logic        seen;

    initial begin
        RST        = 1'b1;
        iobus_addr = '0;
        iobus_out  = '0;
        iobus_wr   = 1'b0;
        in_data    = '0;
        btn_raw    = '0;
        tick();
        tick();
        RST = 1'b0;

        // Reset state
        sb_exp("rst_out0", 32'h0); sb_exp("rst_out1", 32'h0); sb_exp("rst_out2", 32'h0);
        sb_exp("rst_intr", 32'h0); sb_exp("rst_pend", 32'h0);
        sb_cmp(out_data[31:0]); sb_cmp(out_data[63:32]); sb_cmp(out_data[95:64]);
        sb_cmp({31'b0, intr});
        bus_rd(A_PEND, rd); sb_cmp(rd);

        // Output register write
        sb_exp("wr_out1", 32'h0000_A5A5); sb_exp("wr_out0", 32'h0); sb_exp("wr_out2", 32'h0);
        bus_wr(A_OUT1, 32'h0000_A5A5);
        sb_cmp(out_data[63:32]); sb_cmp(out_data[31:0]); sb_cmp(out_data[95:64]);

        // Writes to input window / unaligned output address are ignored
        sb_exp("wr_ignored_out0", 32'h0); sb_exp("wr_unaligned_out2", 32'h0);
        bus_wr(A_IN0, 32'hDEAD_BEEF);
        bus_wr(A_OUT2 + 32'd1, 32'h1111_2222);
        sb_cmp(out_data[31:0]); sb_cmp(out_data[95:64]);

        // Input port reads, combinational
        in_data[63:32] = 32'h0000_1234;
        in_data[31:0]  = 32'h0BAD_F00D;
        sb_exp("rd_in1", 32'h0000_1234);
        bus_rd(A_IN1, rd); sb_cmp(rd);
        sb_exp("rd_in0", 32'h0BAD_F00D);
        bus_rd(A_IN0, rd); sb_cmp(rd);
        sb_exp("rd_unaligned", 32'h0);
        bus_rd(32'h1100_8006, rd); sb_cmp(rd);
        sb_exp("rd_undecoded", 32'h0);
        bus_rd(32'h1100_8100, rd); sb_cmp(rd);

        // Output readback depends on build option
`ifdef IOBUS_READBACK_EN
        sb_exp("rd_out1_readback", 32'h0000_A5A5);
`else
        sb_exp("rd_out1_readback", 32'h0);
`endif
        bus_rd(A_OUT1, rd); sb_cmp(rd);

        // Debounce latency on press and release
        btn_raw[2] = 1'b1;
        sb_exp("db_rise_lat", 32'(DB_LAT));
        wait_btn(2, 1'b1, n); sb_cmp(32'(n));
        tick();
        sb_exp("pend_after_press", 32'h4); sb_exp("intr_ien0", 32'h0);
        bus_rd(A_PEND, rd); sb_cmp(rd);
        tick(); sb_cmp({31'b0, intr});
        btn_raw[2] = 1'b0;
        sb_exp("db_fall_lat", 32'(DB_LAT));
        wait_btn(2, 1'b0, n); sb_cmp(32'(n));
        tick();
        sb_exp("pend_no_set_on_fall", 32'h4);
        bus_rd(A_PEND, rd); sb_cmp(rd);
        bus_wr(A_PCLR, 32'h1F);
        sb_exp("pend_pclr_all", 32'h0);
        bus_rd(A_PEND, rd); sb_cmp(rd);

        // 10-cycle glitch is rejected
        seen = 1'b0;
        iobus_addr = A_BTN;
        btn_raw[2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (iobus_in[2] === 1'b1) seen = 1'b1;
        end
        btn_raw[2] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (iobus_in[2] === 1'b1) seen = 1'b1;
        end
        sb_exp("glitch_rejected", 32'h0);
        sb_cmp({31'b0, seen});

        // Interrupt path
        bus_wr(A_IEN, 32'h0000_0004);
        btn_raw[2] = 1'b1;
        sb_exp("db_rise_lat_ien", 32'(DB_LAT));
        wait_btn(2, 1'b1, n); sb_cmp(32'(n));
        tick();
        sb_exp("pend_ien", 32'h4); sb_exp("intr_not_yet", 32'h0); sb_exp("intr_set", 32'h1);
        bus_rd(A_PEND, rd); sb_cmp(rd);
        sb_cmp({31'b0, intr});
        tick(); sb_cmp({31'b0, intr});
        bus_wr(A_PCLR, 32'h0000_0004);
        sb_exp("pend_cleared", 32'h0); sb_exp("intr_cleared", 32'h0);
        bus_rd(A_PEND, rd); sb_cmp(rd);
        tick(); sb_cmp({31'b0, intr});

        // Set beats simultaneous clear
        btn_raw[2] = 1'b0;
        wait_btn(2, 1'b0, n);
        btn_raw[2] = 1'b1;
        sb_exp("db_rise_lat_coll", 32'(DB_LAT));
        wait_btn(2, 1'b1, n); sb_cmp(32'(n));
        bus_wr(A_PCLR, 32'h0000_0004);
        sb_exp("pend_set_wins", 32'h4); sb_exp("intr_after_coll", 32'h1);
        bus_rd(A_PEND, rd); sb_cmp(rd);
        tick(); sb_cmp({31'b0, intr});

        // Reset mid-debounce and during a write
        btn_raw[2] = 1'b0;
        wait_btn(2, 1'b0, n);
        btn_raw[2] = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        iobus_addr = A_OUT2;
        iobus_out  = 32'hFFFF_FFFF;
        iobus_wr   = 1'b1;
        RST        = 1'b1;
        tick();
        RST        = 1'b0;
        iobus_wr   = 1'b0;
        sb_exp("rst2_out0", 32'h0); sb_exp("rst2_out1", 32'h0); sb_exp("rst2_out2", 32'h0);
        sb_exp("rst2_intr", 32'h0); sb_exp("rst2_btn", 32'h0); sb_exp("rst2_pend", 32'h0);
        sb_exp("rst2_ien_no_intr", 32'h0);
        sb_cmp(out_data[31:0]); sb_cmp(out_data[63:32]); sb_cmp(out_data[95:64]);
        sb_cmp({31'b0, intr});
        bus_rd(A_BTN, rd); sb_cmp(rd);
        bus_rd(A_PEND, rd); sb_cmp(rd);
        sb_exp("db_after_rst_lat", 32'(DB_LAT));
        wait_btn(2, 1'b1, n);
        tick(); tick();
        // Pending sets again but IEN was reset, so no interrupt.
        sb_cmp({31'b0, intr});
        sb_cmp(32'(n));

        if (exp_q.size() != 0) chk("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
